// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-requester round-robin APB master with wait-state timeout
module apb_master_arb #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            i_m0_valid,
  output logic            o_m0_ready,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic            i_m0_write,
  input  logic [DW-1:0]   i_m0_wdata,
  input  logic [DW/8-1:0] i_m0_strb,
  output logic            o_m0_rsp_valid,
  output logic [DW-1:0]   o_m0_rdata,
  output logic            o_m0_err,
  input  logic            i_m1_valid,
  output logic            o_m1_ready,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic            i_m1_write,
  input  logic [DW-1:0]   i_m1_wdata,
  input  logic [DW/8-1:0] i_m1_strb,
  output logic            o_m1_rsp_valid,
  output logic [DW-1:0]   o_m1_rdata,
  output logic            o_m1_err,
  output logic [AW-1:0]   o_paddr,
  output logic            o_pwrite,
  output logic            o_psel,
  output logic            o_penable,
  output logic [DW-1:0]   o_pwdata,
  output logic [DW/8-1:0] o_pstrb,
  input  logic [DW-1:0]   i_prdata,
  input  logic            i_pslverr,
  input  logic            i_pready,
  output logic            o_timeout
);
  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  state_e         state_q, state_d;
  logic           rr_q, rr_d;
  logic           owner_q, owner_d;
  logic [AW-1:0]  paddr_q, paddr_d;
  logic           pwrite_q, pwrite_d;
  logic           psel_q, psel_d;
  logic           penable_q, penable_d;
  logic [DW-1:0]  pwdata_q, pwdata_d;
  logic [SW-1:0]  pstrb_q, pstrb_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic           rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic [DW-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic           err0_q, err0_d, err1_q, err1_d;
  logic           timeout_q, timeout_d;
  logic           gnt0, gnt1, done, abort;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_err;

  // rr_q=0 favours m0 when both requesters are valid
  assign gnt0 = i_m0_valid & (~i_m1_valid | ~rr_q);
  assign gnt1 = i_m1_valid & (~i_m0_valid | rr_q);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    wait_d     = wait_q;
    rsp0_d     = 1'b0;
    rsp1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    err0_d     = err0_q;
    err1_d     = err1_q;
    timeout_d  = 1'b0;
    o_m0_ready = 1'b0;
    o_m1_ready = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt0 || gnt1) begin
          o_m0_ready = gnt0;
          o_m1_ready = gnt1;
          owner_d    = gnt1;
          if (i_m0_valid && i_m1_valid) rr_d = ~gnt1;
          paddr_d    = gnt1 ? i_m1_addr  : i_m0_addr;
          pwrite_d   = gnt1 ? i_m1_write : i_m0_write;
          pwdata_d   = '0;
          pstrb_d    = '0;
          if (pwrite_d) begin
            pwdata_d = gnt1 ? i_m1_wdata : i_m0_wdata;
            pstrb_d  = gnt1 ? i_m1_strb  : i_m0_strb;
          end
          psel_d     = 1'b1;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (i_pready) begin
          done      = 1'b1;
          rsp_err   = i_pslverr;
          rsp_rdata = pwrite_q ? '0 : i_prdata;
        end else if (TIMEOUT != 0 && int'(wait_q) == TIMEOUT - 1) begin
          // This is the TIMEOUT-th cycle without pready
          abort     = 1'b1;
          rsp_err   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
        if (done || abort) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
          if (owner_q) begin
            rsp1_d   = 1'b1;
            rdata1_d = rsp_rdata;
            err1_d   = rsp_err;
          end else begin
            rsp0_d   = 1'b1;
            rdata0_d = rsp_rdata;
            err0_d   = rsp_err;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      wait_q    <= '0;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      wait_q    <= wait_d;
      rsp0_q    <= rsp0_d;
      rsp1_q    <= rsp1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_paddr        = paddr_q;
  assign o_pwrite       = pwrite_q;
  assign o_psel         = psel_q;
  assign o_penable      = penable_q;
  assign o_pwdata       = pwdata_q;
  assign o_pstrb        = pstrb_q;
  assign o_m0_rsp_valid = rsp0_q;
  assign o_m0_rdata     = rdata0_q;
  assign o_m0_err       = err0_q;
  assign o_m1_rsp_valid = rsp1_q;
  assign o_m1_rdata     = rdata1_q;
  assign o_m1_err       = err1_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - directed vector bench for apb_master_arb
module tb_apb_master_arb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = 4;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic i_m0_valid = 0, i_m0_write = 0, i_m1_valid = 0, i_m1_write = 0;
  logic [AW-1:0] i_m0_addr = '0, i_m1_addr = '0;
  logic [DW-1:0] i_m0_wdata = '0, i_m1_wdata = '0, i_prdata = '0;
  logic [SW-1:0] i_m0_strb = '0, i_m1_strb = '0;
  logic i_pslverr = 0, i_pready = 0;
  logic o_m0_ready, o_m0_rsp_valid, o_m0_err, o_m1_ready, o_m1_rsp_valid, o_m1_err;
  logic [DW-1:0] o_m0_rdata, o_m1_rdata, o_pwdata;
  logic [AW-1:0] o_paddr;
  logic [SW-1:0] o_pstrb;
  logic o_pwrite, o_psel, o_penable, o_timeout;

  apb_master_arb #(.DW(DW), .AW(AW), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .i_m0_valid(i_m0_valid), .o_m0_ready(o_m0_ready), .i_m0_addr(i_m0_addr),
    .i_m0_write(i_m0_write), .i_m0_wdata(i_m0_wdata), .i_m0_strb(i_m0_strb),
    .o_m0_rsp_valid(o_m0_rsp_valid), .o_m0_rdata(o_m0_rdata), .o_m0_err(o_m0_err),
    .i_m1_valid(i_m1_valid), .o_m1_ready(o_m1_ready), .i_m1_addr(i_m1_addr),
    .i_m1_write(i_m1_write), .i_m1_wdata(i_m1_wdata), .i_m1_strb(i_m1_strb),
    .o_m1_rsp_valid(o_m1_rsp_valid), .o_m1_rdata(o_m1_rdata), .o_m1_err(o_m1_err),
    .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwdata(o_pwdata), .o_pstrb(o_pstrb), .i_prdata(i_prdata),
    .i_pslverr(i_pslverr), .i_pready(i_pready), .o_timeout(o_timeout)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int            req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waits;
    logic [DW-1:0] prdata;
    logic          slverr;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vt[7];
  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (r == 0) begin
      i_m0_valid = v; i_m0_write = w; i_m0_addr = a; i_m0_wdata = d; i_m0_strb = s;
    end else begin
      i_m1_valid = v; i_m1_write = w; i_m1_addr = a; i_m1_wdata = d; i_m1_strb = s;
    end
  endtask

  function automatic logic rdy(input int r);
    return (r == 1) ? o_m1_ready : o_m0_ready;
  endfunction
  function automatic logic rsp(input int r);
    return (r == 1) ? o_m1_rsp_valid : o_m0_rsp_valid;
  endfunction
  function automatic logic [DW-1:0] rdat(input int r);
    return (r == 1) ? o_m1_rdata : o_m0_rdata;
  endfunction
  function automatic logic er(input int r);
    return (r == 1) ? o_m1_err : o_m0_err;
  endfunction

  task automatic do_xfer(input vec_t v);
    logic [DW-1:0] exp_wd;
    logic [SW-1:0] exp_st;
    logic [43:0]   exp_bus;
    exp_wd = v.wr ? v.wdata : '0;
    exp_st = v.wr ? v.strb : '0;
    set_req(v.req, 1'b1, v.wr, v.addr, v.wdata, v.strb);
    @(negedge pclk);
    chk("accept_ready", 64'(rdy(v.req)), 64'(1'b1));
    chk("other_ready", 64'(rdy(1 - v.req)), 64'(1'b0));
    tick;
    set_req(v.req, 1'b0, ~v.wr, ~v.addr, $urandom, '1);
    @(negedge pclk);
    exp_bus = {2'b10, v.addr, v.wr, exp_wd, exp_st};
    chk("setup_bus", 64'({o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb}), 64'(exp_bus));
    exp_bus[42] = 1'b1;
    tick;
    for (int i = 0; i < v.waits; i++) begin
      @(negedge pclk);
      n_vec++;
      if ({o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb} !== exp_bus) begin
        n_miss++;
        $display("FAIL wait_bus: got 0x%0h, expected 0x%0h",
                 {o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb}, exp_bus);
      end
      tick;
    end
    i_pready = 1'b1; i_prdata = v.prdata; i_pslverr = v.slverr;
    @(negedge pclk);
    chk("access_bus", 64'({o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb}), 64'(exp_bus));
    tick;
    i_pready = 1'b0; i_prdata = $urandom; i_pslverr = 1'b0;
    @(negedge pclk);
    chk("rsp_valid", 64'(rsp(v.req)), 64'(1'b1));
    chk("rsp_other", 64'(rsp(1 - v.req)), 64'(1'b0));
    chk("rsp_rdata", 64'(rdat(v.req)), 64'(v.exp_rdata));
    chk("rsp_err", 64'(er(v.req)), 64'(v.exp_err));
    chk("rsp_timeout", 64'(o_timeout), 64'(1'b0));
    chk("idle_bus", 64'({o_psel, o_penable}), 64'(2'b00));
    tick;
    @(negedge pclk);
    chk("rsp_pulse_end", 64'(rsp(v.req)), 64'(1'b0));
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    vt[0] = '{0, 1'b1, 5'h08, 32'hA5A5_0001, 4'hF, 0,  32'h1234_5678, 1'b0, 32'h0,         1'b0};
    vt[1] = '{1, 1'b0, 5'h0C, 32'h0,         4'h0, 2,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vt[2] = '{0, 1'b1, 5'h10, 32'h0000_00C3, 4'h3, 1,  32'h7777_7777, 1'b1, 32'h0,         1'b1};
    vt[3] = '{1, 1'b0, 5'h1F, 32'h0,         4'h0, 15, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0};
    vt[4] = '{0, 1'b0, 5'h04, 32'hFFFF_FFFF, 4'hF, 0,  32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1};
    vt[5] = '{1, 1'b1, 5'h1C, 32'h55AA_55AA, 4'h9, 3,  32'h1111_2222, 1'b0, 32'h0,         1'b0};
    vt[6] = '{0, 1'b0, 5'h02, 32'h0,         4'h0, 1,  32'h0000_BEEF, 1'b0, 32'h0000_BEEF, 1'b0};

    tick; tick;
    @(negedge pclk);
    chk("rst_apb", 64'({o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb}), 64'(44'h0));
    chk("rst_rsp", 64'({o_m0_rsp_valid, o_m1_rsp_valid, o_m0_err, o_m1_err, o_timeout}), 64'(5'h0));
    chk("rst_rdata", 64'({o_m0_rdata, o_m1_rdata}), 64'h0);
    chk("rst_ready", 64'({o_m0_ready, o_m1_ready}), 64'(2'b00));
    tick;
    preset = 1'b0;
    tick;

    for (int i = 0; i < 6; i++) do_xfer(vt[i]);

    set_req(0, 1'b1, 1'b1, 5'h01, 32'h1111, 4'hF);
    set_req(1, 1'b1, 1'b0, 5'h02, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      int own;
      own = k % 2;
      @(negedge pclk);
      n_vec++;
      if (rdy(own) !== 1'b1) begin
        n_miss++;
        $display("FAIL rr_ready_win: k=%0d", k);
      end
      n_vec++;
      if (rdy(1 - own) !== 1'b0) begin
        n_miss++;
        $display("FAIL rr_ready_lose: k=%0d", k);
      end
      if (k > 0) begin
        n_vec++;
        if (rsp(1 - own) !== 1'b1) begin
          n_miss++;
          $display("FAIL rr_rsp_prev: k=%0d", k);
        end
        n_vec++;
        if (rsp(own) !== 1'b0) begin
          n_miss++;
          $display("FAIL rr_rsp_cur: k=%0d", k);
        end
      end
      if (k == 2) begin
        n_vec++;
        if (o_m1_rdata !== 32'h101) begin
          n_miss++;
          $display("FAIL rr_m1_rdata: got 0x%0h", o_m1_rdata);
        end
      end
      tick;
      if (k == 3) begin
        i_m0_valid = 1'b0;
        i_m1_valid = 1'b0;
      end
      @(negedge pclk);
      n_vec++;
      if (o_paddr !== ((own == 1) ? 5'h02 : 5'h01)) begin
        n_miss++;
        $display("FAIL rr_paddr: k=%0d got 0x%0h", k, o_paddr);
      end
      n_vec++;
      if ({o_m0_ready, o_m1_ready} !== 2'b00) begin
        n_miss++;
        $display("FAIL rr_busy_ready: k=%0d", k);
      end
      tick;
      i_pready = 1'b1;
      i_prdata = 32'(32'h100 + k);
      tick;
      i_pready = 1'b0;
    end
    @(negedge pclk);
    chk("rr_last_rsp", 64'({o_m0_rsp_valid, o_m1_rsp_valid}), 64'(2'b01));
    chk("rr_last_rdata", 64'(o_m1_rdata), 64'(32'h103));
    tick;

    set_req(0, 1'b1, 1'b0, 5'h14, 32'h0, 4'h0);
    i_prdata = 32'hFFFF_FFFF;
    @(negedge pclk);
    chk("to_ready", 64'(o_m0_ready), 64'(1'b1));
    tick;
    set_req(0, 1'b0, 1'b0, 5'h00, 32'h0, 4'h0);
    tick;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      if (!o_psel) break;
      if (o_penable) cnt++;
      n_vec++;
      if ({o_m0_rsp_valid, o_timeout} !== 2'b00) begin
        n_miss++;
        $display("FAIL to_no_early_rsp: cycle %0d", i);
      end
      tick;
    end
    chk("to_access_cycles", 64'(cnt), 64'(16));
    chk("to_rsp", 64'({o_psel, o_penable, o_m0_rsp_valid, o_m0_err, o_timeout}), 64'(5'b00111));
    chk("to_rdata", 64'(o_m0_rdata), 64'(32'h0));
    tick;
    @(negedge pclk);
    chk("to_pulse_end", 64'({o_timeout, o_m0_rsp_valid}), 64'(2'b00));
    tick;
    do_xfer(vt[6]);

    set_req(0, 1'b1, 1'b1, 5'h18, 32'h77, 4'hF);
    set_req(1, 1'b1, 1'b0, 5'h19, 32'h0, 4'h0);
    @(negedge pclk);
    chk("rs_first_win", 64'({o_m0_ready, o_m1_ready}), 64'(2'b10));
    tick;
    i_m0_valid = 1'b0;
    i_m1_valid = 1'b0;
    tick;
    @(negedge pclk);
    chk("rs_in_access", 64'({o_psel, o_penable}), 64'(2'b11));
    preset = 1'b1;
    i_pready = 1'b1;
    tick;
    @(negedge pclk);
    chk("rs_dropped", 64'({o_psel, o_penable, o_m0_rsp_valid, o_m1_rsp_valid}), 64'(4'b0000));
    chk("rs_paddr", 64'(o_paddr), 64'(5'h00));
    i_pready = 1'b0;
    tick;
    preset = 1'b0;
    i_m0_valid = 1'b1;
    i_m1_valid = 1'b1;
    @(negedge pclk);
    chk("rs_m0_first", 64'({o_m0_ready, o_m1_ready}), 64'(2'b10));
    chk("rs_no_rsp", 64'({o_m0_rsp_valid, o_m1_rsp_valid}), 64'(2'b00));
    tick;
    i_m0_valid = 1'b0;
    i_m1_valid = 1'b0;
    tick;
    i_pready = 1'b1;
    tick;
    i_pready = 1'b0;
    @(negedge pclk);
    chk("rs_rsp", 64'({o_m0_rsp_valid, o_m1_rsp_valid, o_m0_err}), 64'(3'b100));
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- Two-requester APB master. Arbitrates between two local requesters (m0, m1) and sequences single APB transfers (SETUP -> ACCESS) onto one shared APB bus.
- Sits between internal controllers (e.g. config sequencer, debug port) and the register-map APB slaves.
- Handles slave wait states and returns read data and error per transfer.
- Aborts transfers that exceed a programmable wait-state timeout.

Parameters:
- DW, 32, data width; byte-multiple.
- AW, 5, address width; max 32.
- TIMEOUT, 16, max ACCESS cycles without pready before abort; 0 disables timeout.
- SW, DW/8, strobe width; derived (localparam).

Ports:
- pclk  in  1  clock
- preset  in  1  synchronous active-high reset
- i_mN_valid  in  1  request valid (N=0,1)
- o_mN_ready  out  1  request accepted this cycle
- i_mN_addr  in  AW  request address
- i_mN_write  in  1  1=write, 0=read
- i_mN_wdata  in  DW  write data
- i_mN_strb  in  SW  write strobe
- o_mN_rsp_valid  out  1  one-cycle response pulse
- o_mN_rdata  out  DW  read data; valid with rsp_valid
- o_mN_err  out  1  slave error or timeout; valid with rsp_valid
- o_paddr  out  AW  APB address
- o_pwrite  out  1  APB write
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_pwdata  out  DW  APB write data
- o_pstrb  out  SW  APB strobe
- i_prdata  in  DW  APB read data
- i_pslverr  in  1  APB slave error
- i_pready  in  1  APB ready
- o_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer favours m0, wait counter 0. Reset mid-transfer drops the transfer; no response is issued.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - o_mN_ready is combinational: high only in IDLE, only for the arbitration winner, only while its valid is high.
  - Arbitration: if only one requester is valid, it wins. If both are valid, the requester indicated by the pointer wins, and the pointer then points to the other one.
  - On accept, register addr/write/wdata/strb onto the APB outputs and remember the owner. Set o_psel=1, go to SETUP.
- SETUP: o_psel=1, o_penable=0 for exactly one cycle. Next cycle: o_penable=1, go to ACCESS.
- ACCESS:
  - psel, penable, addr, write, wdata and strb are held stable.
  - When i_pready=1: sample i_pslverr. Sample i_prdata for reads; writes return rdata=0.
  - Also on i_pready=1: drop psel/penable, return to IDLE, and assert the owner's o_mN_rsp_valid (registered) in the following cycle.
- Timeout:
  - The wait counter increments on each ACCESS cycle with i_pready=0.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: abort. Drop psel/penable, respond err=1 and rdata=0, pulse o_timeout, go to IDLE.
  - The counter clears on entry to ACCESS.
- A pready arriving on the same cycle the counter reaches TIMEOUT wins (normal completion, no timeout).
- Minimum transfer is 3 cycles: accept, SETUP, ACCESS with pready. A new request can be accepted in the same cycle the previous response pulses (the IDLE cycle).
- Master outputs never change while psel=1 except penable (SETUP->ACCESS).
- o_pwdata and o_pstrb are driven 0 for reads.
- Requester inputs are ignored outside the accept cycle.

Test Plan:
1. m0 write addr=0x08, wdata=0xA5A5_0001, strb=0xF; slave pready in first ACCESS cycle -> psel seen 2 cycles, penable 1 cycle; m0_rsp_valid 1 cycle after completion with err=0, rdata=0.
2. m1 read addr=0x0C; slave holds pready low 2 ACCESS cycles, then prdata=0xDEADBEEF -> m1_rsp_valid with rdata=0xDEADBEEF, err=0; APB signals stable throughout wait.
3. m0 and m1 both valid continuously, 4 transfers -> grants alternate m0,m1,m0,m1; each response goes only to its owner.
4. Write to addr=0x10 with i_pslverr=1 at pready -> owner's err=1, o_timeout=0.
5. TIMEOUT=16, slave never asserts pready -> abort after 16 ACCESS cycles, err=1, rdata=0, o_timeout pulse. A follow-up request then completes normally.
6. preset asserted during ACCESS -> next cycle psel=penable=0, no rsp_valid. After deassert, m1 and m0 both valid -> m0 granted first.
